if_stage: RTL and testbench



---
 rtl/if_stage.sv | 112 +++++++++++
 tb/tb_if_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC, single-outstanding imem fetch FSM, IF/ID register PR1.
// Optional performance counters are built only when IF_PERF_EN is defined.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [63:0]  branch_target,
  output logic         imem_req,
  output logic [63:0]  imem_addr,
  input  logic         imem_valid,
  input  logic [31:0]  imem_rdata,
  output logic [499:0] PR1,
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [31:0] hold_insn;
  logic        deliver;
  logic [31:0] deliver_insn;

  function automatic logic [499:0] pack_pr1(input logic [63:0] fpc, input logic [31:0] insn);
    logic [499:0] r;
    r          = '0;
    r[31:0]    = insn;
    r[95:32]   = fpc;
    r[159:96]  = fpc + 64'd4;
    r[160]     = 1'b1;
    return r;
  endfunction

  // Handshake: imem_req high means the request is accepted that same cycle; imem_valid
  // strobes the single response at least one cycle later. A redirect in REQ suppresses
  // the request so that nothing is left outstanding when the FSM re-enters REQ.
  assign imem_req  = (state == S_REQ) && !reset && !branch_taken;
  assign imem_addr = pc;

  // An instruction reaches PR1 this cycle (no stall, no redirect, no reset).
  assign deliver = !reset && !branch_taken && !stall &&
                   (((state == S_WAIT) && imem_valid) || (state == S_HOLD));
  assign deliver_insn = (state == S_HOLD) ? hold_insn : imem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      PR1       <= '0;
      hold_insn <= '0;
    end else if (branch_taken) begin
      // A request still in flight must be drained before the target can be fetched.
      pc        <= {branch_target[63:2], 2'b00};
      PR1       <= '0;
      hold_insn <= '0;
      if (((state == S_WAIT) || (state == S_DRAIN)) && !imem_valid)
        state <= S_DRAIN;
      else
        state <= S_REQ;
    end else begin
      if (!stall)
        PR1 <= '0;
      if (deliver) begin
        PR1 <= pack_pr1(pc, deliver_insn);
        pc  <= pc + 64'd4;
      end
      case (state)
        S_REQ:   state <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (stall) begin
              hold_insn <= imem_rdata;
              state     <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD:  if (!stall) state <= S_REQ;
        S_DRAIN: if (imem_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (deliver)
        fetch_count <= fetch_count + 32'd1;
      if (stall)
        stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stall/redirect/latency/reset traffic,
// checked cycle by cycle against a transaction-level model of the fetch stream.
module tb_if_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         branch_taken;
  logic [63:0]  branch_target;
  logic         imem_req;
  logic [63:0]  imem_addr;
  logic         imem_valid;
  logic [31:0]  imem_rdata;
  logic [499:0] PR1;
  logic [31:0]  fetch_count;
  logic [31:0]  stall_count;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .PR1           (PR1),
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
  );

  int total = 0;
  int bad   = 0;

  // instruction memory model
  bit          mem_busy;
  logic [63:0] mem_addr;
  int          mem_cnt;
  bit          mem_kill;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // reference model: instructions fetched but not yet shown on PR1
  logic [499:0] exp_q[$];
  logic [499:0] exp_pr1;
  logic [63:0]  model_pc;
  logic [63:0]  last_req_addr;
  int unsigned  m_fetch;
  int unsigned  m_stall;
  int           idle;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hF840_0000 + a[31:0];
  endfunction

  function automatic logic [499:0] entry(input logic [63:0] a, input logic [31:0] d);
    return {339'd0, 1'b1, a + 64'd4, a, d};
  endfunction

  function automatic logic [31:0] exp_fc();
`ifdef IF_PERF_EN
    return m_fetch;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_sc();
`ifdef IF_PERF_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [499:0] got, input logic [499:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    repeat (n) @(negedge clk);
    chk("rst_pr1", PR1, '0);
    chk("rst_req", 500'(imem_req), '0);
    chk("rst_fetch_count", 500'(fetch_count), '0);
    chk("rst_stall_count", 500'(stall_count), '0);
    reset = 1'b0;
    mem_busy = 1'b0; mem_kill = 1'b0; mem_cnt = 0;
    exp_q.delete(); exp_pr1 = '0; model_pc = 64'h0;
    m_fetch = 0; m_stall = 0; idle = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, see the request, step the model,
  // then compare outputs at the next falling edge.
  task automatic cycle(input bit st, input bit br, input logic [63:0] tgt);
    bit          v = 1'b0;
    bit          vkill = 1'b0;
    logic [63:0] vaddr = '0;
    logic [31:0] vdata = '0;
    stall = st; branch_taken = br; branch_target = tgt;
    imem_valid = 1'b0; imem_rdata = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        v = 1'b1; vkill = mem_kill; vaddr = mem_addr; vdata = mem_word(mem_addr);
        mem_busy = 1'b0;
        imem_valid = 1'b1; imem_rdata = vdata;
      end else if (br) begin
        mem_kill = 1'b1;
      end
    end
    #1;
    if (imem_req) begin
      chk("dup_req", 500'(mem_busy), '0);
      chk("req_addr", 500'(imem_addr), 500'(model_pc));
      mem_busy = 1'b1; mem_addr = imem_addr; mem_kill = 1'b0;
      mem_cnt = $urandom_range(lat_hi, lat_lo);
      last_req_addr = imem_addr; idle = 0;
    end else begin
      idle++;
      if (idle > 40) begin
        chk("no_req_timeout", 500'(idle), '0);
        idle = 0;
      end
    end
    if (br) begin
      exp_q.delete();
      exp_pr1 = '0;
      model_pc = tgt - (tgt % 64'd4);
    end else begin
      if (v && !vkill) exp_q.push_back(entry(vaddr, vdata));
      if (!st) begin
        if (exp_q.size() > 0) begin
          exp_pr1 = exp_q.pop_front();
          model_pc = exp_pr1[95:32] + 64'd4;
          m_fetch++;
        end else begin
          exp_pr1 = '0;
        end
      end
    end
    if (st) m_stall++;
    @(negedge clk);
    chk("pr1", PR1, exp_pr1);
    chk("fetch_count", 500'(fetch_count), 500'(exp_fc()));
    chk("stall_count", 500'(stall_count), 500'(exp_sc()));
  endtask

  initial begin
    // basic fetch at L=1
    lat_lo = 1; lat_hi = 1;
    do_reset(2);
    cycle(0, 0, '0); cycle(0, 0, '0);
    chk("c2_pc0", 500'({PR1[160], PR1[95:32]}), 500'({1'b1, 64'h0}));
    cycle(0, 0, '0); cycle(0, 0, '0);
    chk("c4_pc4", 500'({PR1[160], PR1[95:32]}), 500'({1'b1, 64'h4}));
    chk("c4_pc4_plus4", 500'(PR1[159:96]), 500'(64'h8));

    // stall across the PC=8 response
    cycle(1, 0, '0); cycle(1, 0, '0); cycle(1, 0, '0);
    chk("stall_hold_pc4", 500'({PR1[160], PR1[95:32]}), 500'({1'b1, 64'h4}));
    cycle(0, 0, '0);
    chk("after_stall_pc8", 500'({PR1[160], PR1[95:32]}), 500'({1'b1, 64'h8}));

    // redirect while waiting on a slow response
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10 && !mem_busy; i++) cycle(0, 0, '0);
    cycle(0, 1, 64'h103);
    chk("br_pr1_zero", PR1, '0);
    last_req_addr = '1;
    for (int i = 0; i < 12 && last_req_addr != 64'h100; i++) cycle(0, 0, '0);
    chk("br_target_req", 500'(last_req_addr), 500'(64'h100));
    repeat (6) cycle(0, 0, '0);

    // redirect and stall together
    cycle(1, 1, 64'h200);
    chk("br_stall_zero", PR1, '0);
    repeat (8) cycle(0, 0, '0);

    // PC wrap
    lat_lo = 1; lat_hi = 1;
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    for (int i = 0; i < 12 && !(PR1[160] === 1'b1 && PR1[95:32] === 64'hFFFF_FFFF_FFFF_FFFC); i++)
      cycle(0, 0, '0);
    chk("wrap_pc", 500'(PR1[95:32]), 500'(64'hFFFF_FFFF_FFFF_FFFC));
    chk("wrap_pc_plus4", 500'(PR1[159:96]), '0);
    last_req_addr = 64'h1;
    cycle(0, 0, '0);
    chk("wrap_next_req", 500'(last_req_addr), '0);

    // counters: 10 fetches, 4 stall cycles
    do_reset(3);
    repeat (20) cycle(0, 0, '0);
    repeat (4) cycle(1, 0, '0);
`ifdef IF_PERF_EN
    chk("perf_fetch10", 500'(fetch_count), 500'(32'd10));
    chk("perf_stall4", 500'(stall_count), 500'(32'd4));
`else
    chk("perf_fetch_off", 500'(fetch_count), '0);
    chk("perf_stall_off", 500'(stall_count), '0);
`endif

    // random traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset(1 + $urandom_range(0, 1));
      else
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
